inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/mips_pkg.sv | 9 +
 rtl/ifq_ram.sv | 17 +
 rtl/inst_fetch_queue.sv | 70 +++++++
 tb/tb_inst_fetch_queue.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath width, PC increment and fetch-queue entry type.
package mips_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_ram.sv
// ifq_ram: DEPTH-entry fetch-queue storage, one sync write port, one async read port, unreset array.
module ifq_ram
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  ifq_entry_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output ifq_entry_t               rdata
);
  ifq_entry_t mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC plus instruction queue to decode; IFQ_BYPASS_EN adds an empty-queue same-cycle bypass.
module inst_fetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_inst,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [31:0]            deq_inst,
  output logic [31:0]            deq_pc4,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]   head, tail;
  logic [XLEN-1:0] pc, pc4;
  ifq_entry_t      rd_entry;
  logic            full, pop, push, wr;
  assign imem_addr = pc;
  assign pc4 = pc + PC_INC;
  assign full = count == (AW+1)'(DEPTH);
  assign pop = (count != '0) && deq_ready && !redirect_valid;
  assign push = !redirect_valid && (!full || pop);
`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass = (count == '0) && !redirect_valid;
  // a bypassed word taken by decode this cycle never enters storage
  assign wr = push && !(bypass && deq_ready);
  assign deq_valid = (count != '0) || bypass;
  assign deq_inst = bypass ? imem_inst : rd_entry.inst;
  assign deq_pc4 = bypass ? pc4 : rd_entry.pc4;
`else
  assign wr = push;
  assign deq_valid = count != '0;
  assign deq_inst = rd_entry.inst;
  assign deq_pc4 = rd_entry.pc4;
`endif
  ifq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr),
    .waddr (tail),
    .wdata ('{inst: imem_inst, pc4: pc4}),
    .raddr (head),
    .rdata (rd_entry)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      if (push) pc <= pc4;
      if (pop) head <= head + 1'b1;
      if (wr) tail <= tail + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed stimulus with a pc4 scoreboard drained by a negedge monitor.
module tb_inst_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, redirect_valid, deq_ready, deq_valid;
  logic [31:0] redirect_pc, imem_addr, imem_inst, deq_inst, deq_pc4;
  logic [2:0]  count;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return (a == 32'h2000) ? 32'h2008_0005 : (a ^ 32'hDEAD_BEEF);
  endfunction
  assign imem_inst = imem_fn(imem_addr);

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .deq_ready      (deq_ready),
    .deq_valid      (deq_valid),
    .deq_inst       (deq_inst),
    .deq_pc4        (deq_pc4),
    .count          (count)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // monitor: every accepted (non-flushed) head word must be the next expected one
  initial forever begin
    @(negedge clk);
    if (!rst && deq_valid && deq_ready && !redirect_valid) begin
      if (exp_q.size() == 0) chk("unexpected_deq", deq_pc4, 32'hxxxx_xxxx);
      else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("deq_pc4", deq_pc4, e);
        chk("deq_inst", deq_inst, imem_fn(e - 32'd4));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; deq_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(deq_valid), 0);
    exp_q.push_back(32'h104); exp_q.push_back(32'h108); exp_q.push_back(32'h10C);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (4) edge1();
    deq_ready = 1'b0;
    repeat (6) edge1();
    @(negedge clk);
    chk("sat_count", 32'(count), 4);
    chk("sat_addr", imem_addr, 32'h11C);
    exp_q.push_back(32'h110);
    edge1(); deq_ready = 1'b1;
    edge1(); deq_ready = 1'b0;
    @(negedge clk);
    chk("fullpop_count", 32'(count), 4);
    chk("fullpop_addr", imem_addr, 32'h120);
    chk("fullpop_head", deq_pc4, 32'h114);
    edge1(); redirect_valid = 1'b1; redirect_pc = 32'h4000; deq_ready = 1'b1;
    edge1(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_count", 32'(count), 0);
    chk("redir_valid", 32'(deq_valid), 0);
    chk("redir_addr", imem_addr, 32'h4000);
    exp_q.push_back(32'h4004);
    edge1();
    edge1(); redirect_valid = 1'b1; redirect_pc = 32'h5000;
    edge1(); redirect_pc = 32'h6000;
    edge1(); redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir2_addr", imem_addr, 32'h6000);
    exp_q.push_back(32'h6004); exp_q.push_back(32'h6008);
    edge1(); edge1(); edge1(); deq_ready = 1'b0;
    edge1(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; deq_ready = 1'b1;
    edge1(); redirect_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    edge1();
    @(negedge clk);
    chk("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
    edge1();
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", deq_pc4, 32'h0);
    edge1(); deq_ready = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 0);
    redirect_valid = 1'b1; redirect_pc = 32'h7000;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_addr", imem_addr, 32'h100);
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_valid", 32'(deq_valid), 0);
    edge1();
    chk("rst_redir_ignored", imem_addr, 32'h100);
    redirect_valid = 1'b0; rst = 1'b0;
    edge1();
    @(negedge clk);
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_addr", imem_addr, 32'h104);
    chk("post_rst_head", deq_pc4, 32'h104);
`ifdef IFQ_BYPASS_EN
    edge1(); redirect_valid = 1'b1; redirect_pc = 32'h2000;
    edge1(); redirect_valid = 1'b0; deq_ready = 1'b1;
    exp_q.push_back(32'h2004);
    @(negedge clk);
    chk("byp_valid", 32'(deq_valid), 1);
    chk("byp_inst", deq_inst, 32'h2008_0005);
    edge1(); deq_ready = 1'b0;
    chk("byp_count", 32'(count), 0);
`endif
    edge1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
